// File: rtl/fpcvt_w_s_if.sv
// Handshake bundle for the float-to-int converter: operand side (in_*) and result side (out_*).
interface fpcvt_w_s_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;

    modport master (
        output in_valid, rs1, is_unsigned, rm, out_ready,
        input  in_ready, out_valid, result, fflags
    );

    modport slave (
        input  in_valid, rs1, is_unsigned, rm, out_ready,
        output in_ready, out_valid, result, fflags
    );
endinterface

// File: rtl/fpcvt_w_s.sv
// Three-stage FCVT.W.S / FCVT.WU.S converter: unpack, align, round/saturate.
// Define FPCVT_RM_EN to honor rm; otherwise every conversion truncates (RTZ).
module fpcvt_w_s (
    input  logic        clk,
    input  logic        resetn,
    fpcvt_w_s_if.slave  bus
);
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

`ifdef FPCVT_RM_EN
    function automatic logic f_round_inc(input logic [2:0] rm, input logic sign,
                                         input logic lsb, input logic grd, input logic stk);
        case (rm)
            RM_RNE:  f_round_inc = grd && (stk || lsb);
            RM_RDN:  f_round_inc = sign && (grd || stk);
            RM_RUP:  f_round_inc = !sign && (grd || stk);
            RM_RMM:  f_round_inc = grd;
            default: f_round_inc = 1'b0;
        endcase
    endfunction
`endif

    // Returns {NV, NX, result}; NV and NX are mutually exclusive.
    function automatic logic [33:0] f_range(input logic nan, input logic inf, input logic sign,
                                            input logic uns, input logic ovf,
                                            input logic [32:0] rmag, input logic inexact);
        logic [31:0] lim_pos;
        logic [31:0] lim_neg;
        logic [32:0] neg;
        lim_pos = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        lim_neg = uns ? 32'h0000_0000 : 32'h8000_0000;
        neg     = 33'd0 - rmag;
        if (nan || (inf && !sign))
            f_range = {2'b10, lim_pos};
        else if (inf)
            f_range = {2'b10, lim_neg};
        else if (!sign)
            f_range = (ovf || rmag > {1'b0, lim_pos}) ? {2'b10, lim_pos} : {1'b0, inexact, rmag[31:0]};
        else if (uns)
            f_range = (ovf || rmag != 33'd0) ? {2'b10, 32'd0} : {1'b0, inexact, 32'd0};
        else
            f_range = (ovf || rmag > 33'h0_8000_0000) ? {2'b10, lim_neg} : {1'b0, inexact, neg[31:0]};
    endfunction

    logic w_adv;
    logic r_vld_p0, r_vld_p1, r_vld_p2;
    logic [31:0] r_result;
    logic [4:0]  r_fflags;

    assign w_adv         = !r_vld_p2 || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld_p2;
    assign bus.result    = r_result;
    assign bus.fflags    = r_fflags;

    // ---- Stage p0: unpack and classify
    logic        r_sign_p0, r_nan_p0, r_inf_p0, r_uns_p0;
    logic [7:0]  r_exp_p0;
    logic [23:0] r_mant_p0;
`ifdef FPCVT_RM_EN
    logic [2:0]  r_rm_p0;
    logic [2:0]  w_rm_eff;
    assign w_rm_eff = (bus.rm > RM_RMM) ? RM_RTZ : bus.rm;
`endif

    always_ff @(posedge clk) begin
        if (!resetn)    r_vld_p0 <= 1'b0;
        else if (w_adv) r_vld_p0 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign_p0 <= bus.rs1[31];
            r_exp_p0  <= bus.rs1[30:23];
            r_mant_p0 <= {|bus.rs1[30:23], bus.rs1[22:0]};
            r_nan_p0  <= (&bus.rs1[30:23]) && (|bus.rs1[22:0]);
            r_inf_p0  <= (&bus.rs1[30:23]) && !(|bus.rs1[22:0]);
            r_uns_p0  <= bus.is_unsigned;
`ifdef FPCVT_RM_EN
            r_rm_p0   <= w_rm_eff;
`endif
        end
    end

    // ---- Stage p1: align mantissa to the integer point, keep guard and sticky
    logic signed [8:0] w_e;
    logic [4:0]  w_sh;
    logic [3:0]  w_lsh;
    logic [47:0] w_wide;
    logic [31:0] w_mag;
    logic        w_grd, w_stk, w_ovf;

    assign w_e = $signed({1'b0, r_exp_p0}) - 9'sd127;

    always_comb begin
        w_sh   = '0;
        w_lsh  = '0;
        w_wide = '0;
        w_mag  = '0;
        w_grd  = 1'b0;
        w_stk  = 1'b0;
        w_ovf  = 1'b0;
        if (w_e < 9'sd0) begin
            w_grd = (w_e == -9'sd1);
            w_stk = (w_e == -9'sd1) ? |r_mant_p0[22:0] : |r_mant_p0;
        end else if (w_e <= 9'sd23) begin
            w_sh   = 5'(9'sd23 - w_e);
            w_wide = {r_mant_p0, 24'd0} >> w_sh;
            w_mag  = {8'd0, w_wide[47:24]};
            w_grd  = w_wide[23];
            w_stk  = |w_wide[22:0];
        end else if (w_e <= 9'sd31) begin
            w_lsh = 4'(w_e - 9'sd23);
            w_mag = {8'd0, r_mant_p0} << w_lsh;
        end else begin
            w_ovf = 1'b1;
        end
    end

    logic        r_sign_p1, r_nan_p1, r_inf_p1, r_uns_p1, r_ovf_p1, r_grd_p1, r_stk_p1;
    logic [31:0] r_mag_p1;
`ifdef FPCVT_RM_EN
    logic [2:0]  r_rm_p1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn)    r_vld_p1 <= 1'b0;
        else if (w_adv) r_vld_p1 <= r_vld_p0;
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_sign_p1 <= r_sign_p0;
            r_nan_p1  <= r_nan_p0;
            r_inf_p1  <= r_inf_p0;
            r_uns_p1  <= r_uns_p0;
            r_ovf_p1  <= w_ovf;
            r_mag_p1  <= w_mag;
            r_grd_p1  <= w_grd;
            r_stk_p1  <= w_stk;
`ifdef FPCVT_RM_EN
            r_rm_p1   <= r_rm_p0;
`endif
        end
    end

    // ---- Stage p2: round, range-check, apply sign
    logic        w_inc;
    logic [32:0] w_rmag;
    logic [33:0] w_out;

`ifdef FPCVT_RM_EN
    assign w_inc = f_round_inc(r_rm_p1, r_sign_p1, r_mag_p1[0], r_grd_p1, r_stk_p1);
`else
    assign w_inc = 1'b0;
`endif
    assign w_rmag = {1'b0, r_mag_p1} + {32'd0, w_inc};
    assign w_out  = f_range(r_nan_p1, r_inf_p1, r_sign_p1, r_uns_p1, r_ovf_p1,
                            w_rmag, r_grd_p1 || r_stk_p1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vld_p2 <= 1'b0;
            r_result <= 32'd0;
            r_fflags <= 5'd0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1;
            r_result <= w_out[31:0];
            r_fflags <= {w_out[33], 3'b000, w_out[32]};
        end
    end
endmodule

// File: tb/tb_fpcvt_w_s.sv
// Scoreboard bench for fpcvt_w_s: directed vectors in, monitor pops and compares outputs.
module tb_fpcvt_w_s;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fpcvt_w_s_if bus();
    fpcvt_w_s dut (.clk(clk), .resetn(resetn), .bus(bus));

    localparam logic [4:0] NV = 5'h10;
    localparam logic [4:0] NX = 5'h01;
    localparam logic [4:0] NO = 5'h00;
    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
`ifdef FPCVT_RM_EN
    localparam bit RM_EN = 1'b1;
`else
    localparam bit RM_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  fl;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int n_pass = 0, n_total = 0, cyc = 0, n_out = 0, base = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_fl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && bus.out_valid) begin
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, ".result"}, bus.result, e.res);
                    chk({e.tag, ".fflags"}, 32'(bus.fflags), 32'(e.fl));
                    if (e.lat) chk({e.tag, ".latency"}, 32'(cyc - e.cyc), 32'd3);
                end
                n_out++;
                stall_prev = 1'b0;
            end else begin
                chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
                if (stall_prev) begin
                    chk("stall.result", bus.result, prev_res);
                    chk("stall.fflags", 32'(bus.fflags), 32'(prev_fl));
                end
                stall_prev = 1'b1;
                prev_res   = bus.result;
                prev_fl    = bus.fflags;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input string tag, input logic [31:0] a, input logic uns,
                        input logic [2:0] rm, input logic [31:0] res, input logic [4:0] fl,
                        input bit lat);
        exp_t e;
        bit done = 1'b0;
        bus.in_valid    = 1'b1;
        bus.rs1         = a;
        bus.is_unsigned = uns;
        bus.rm          = rm;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.tag = tag; e.res = res; e.fl = fl; e.cyc = cyc; e.lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk({tag, ".drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn          = 1'b0;
        bus.in_valid    = 1'b0;
        bus.rs1         = 32'd0;
        bus.is_unsigned = 1'b0;
        bus.rm          = RNE;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.result",    bus.result, 32'd0);
        chk("reset.fflags",    32'(bus.fflags), 32'd0);
        chk("reset.in_ready",  32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        send("pi_rne", 32'h40490FDB, 1'b0, RNE, 32'h0000_0003, NX, 1'b1);
        drain("pi");

        send("1.5_rne", 32'h3FC00000, 1'b0, RNE, RM_EN ? 32'd2 : 32'd1, NX, 1'b0);
        send("1.5_rtz", 32'h3FC00000, 1'b0, RTZ, 32'd1, NX, 1'b0);
        send("1.5_rm7", 32'h3FC00000, 1'b0, 3'b111, 32'd1, NX, 1'b0);
        send("2.5_rne", 32'h40200000, 1'b0, RNE, 32'd2, NX, 1'b0);
        send("2.5_rmm", 32'h40200000, 1'b0, RMM, RM_EN ? 32'd3 : 32'd2, NX, 1'b0);
        send("m1.5_rdn", 32'hBFC00000, 1'b0, RDN, RM_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, NX, 1'b0);
        send("m1.5_rup", 32'hBFC00000, 1'b0, RUP, 32'hFFFF_FFFF, NX, 1'b0);

        send("2p31_s",   32'h4F000000, 1'b0, RNE, 32'h7FFF_FFFF, NV, 1'b0);
        send("2p31_u",   32'h4F000000, 1'b1, RNE, 32'h8000_0000, NO, 1'b0);
        send("m2p31_s",  32'hCF000000, 1'b0, RNE, 32'h8000_0000, NO, 1'b0);
        send("m2p31p_s", 32'hCF000001, 1'b0, RNE, 32'h8000_0000, NV, 1'b0);
        send("2p32_u",   32'h4F800000, 1'b1, RNE, 32'hFFFF_FFFF, NV, 1'b0);
        send("big_s",    32'h4EFFFFFF, 1'b0, RTZ, 32'h7FFF_FF80, NO, 1'b0);

        send("qnan_s",   32'h7FC00000, 1'b0, RNE, 32'h7FFF_FFFF, NV, 1'b0);
        send("minf_u",   32'hFF800000, 1'b1, RNE, 32'h0000_0000, NV, 1'b0);
        send("m0.3_u",   32'hBE99999A, 1'b1, RTZ, 32'h0000_0000, NX, 1'b0);
        send("m0.3_urdn",32'hBE99999A, 1'b1, RDN, 32'h0000_0000, RM_EN ? NV : NX, 1'b0);
        send("m1_u",     32'hBF800000, 1'b1, RTZ, 32'h0000_0000, NV, 1'b0);
        send("denorm_s", 32'h00000001, 1'b0, RNE, 32'h0000_0000, NX, 1'b0);
        send("mzero_s",  32'h80000000, 1'b0, RNE, 32'h0000_0000, NO, 1'b0);
        drain("vectors");

        base = n_out;
        fork
            begin
                send("bp1", 32'h3F800000, 1'b0, RTZ, 32'd1, NO, 1'b0);
                send("bp2", 32'h40000000, 1'b0, RTZ, 32'd2, NO, 1'b0);
                send("bp3", 32'h40400000, 1'b0, RTZ, 32'd3, NO, 1'b0);
                send("bp4", 32'h40800000, 1'b0, RTZ, 32'd4, NO, 1'b0);
                send("bp5", 32'h40A00000, 1'b0, RTZ, 32'd5, NO, 1'b0);
                send("bp6", 32'h40C00000, 1'b0, RTZ, 32'd6, NO, 1'b0);
            end
            begin
                for (int i = 0; i < 100 && n_out < base + 2; i++) begin
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("bp");
        chk("bp.count", 32'(n_out - base), 32'd6);

        send("rst1", 32'h3F800000, 1'b0, RTZ, 32'd1, NO, 1'b0);
        send("rst2", 32'h40000000, 1'b0, RTZ, 32'd2, NO, 1'b0);
        send("rst3", 32'h40400000, 1'b0, RTZ, 32'd3, NO, 1'b0);
        resetn = 1'b0;
        sb.delete();
        base = n_out;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result",    bus.result, 32'd0);
        chk("rst.fflags",    32'(bus.fflags), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst.no_stale", 32'(n_out - base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fpcvt_w_s.md
# fpcvt_w_s

Pipelined single-precision IEEE 754 to 32-bit integer converter (RISC-V FCVT.W.S / FCVT.WU.S). It consumes floats produced by the FP datapath, such as the adder result, and hands integers plus exception flags back to the integer register file. The block is a 3-stage pipeline with valid/ready handshakes on both sides. Backpressure stalls the whole pipeline.

## Interface
Parameters: none.

- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- rs1  in  32  IEEE 754 single-precision source.
- is_unsigned  in  1  1 = FCVT.WU.S, 0 = FCVT.W.S.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  32  converted integer.
- fflags  out  5  {NV,DZ,OF,UF,NX}. DZ, OF and UF are always 0.

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Every stage register loads only when adv=1. A transfer occurs when in_valid && in_ready.
- S1, unpack/classify:
  - Latch sign, exp[7:0] and mant24 = {exp!=0, m[22:0]}.
  - Set the NaN flag when exp=FF and m!=0. Set the inf flag when exp=FF and m=0.
  - Latch is_unsigned and the effective rm.
- S2, align:
  - e = exp-127, signed 9-bit.
  - e<0: mag=0; guard = (e==-1); sticky = mant24 bits not covered by guard are nonzero.
  - 0<=e<=23: mag = mant24>>(23-e); guard = next bit below; sticky = OR of the remaining lower bits.
  - 24<=e<=31: mag = mant24<<(e-23); guard=0; sticky=0.
  - e>=32: set the ovf flag; mag is don't-care.
- S3, round, range and sign:
  - inc per rm, using lsb = mag[0]:
    - RNE: guard && (sticky || lsb).
    - RTZ: 0.
    - RDN: sign && (guard||sticky).
    - RUP: !sign && (guard||sticky).
    - RMM: guard.
  - rmag = mag + inc, 33-bit.
  - inexact = guard||sticky.
- Range and output, applied in priority order:
  - NaN or +inf → signed 0x7FFFFFFF, unsigned 0xFFFFFFFF, NV=1.
  - -inf → signed 0x80000000, unsigned 0x00000000, NV=1.
  - Signed, positive: if ovf or rmag>0x7FFFFFFF → 0x7FFFFFFF, NV=1.
  - Signed, negative: if ovf or rmag>0x80000000 → 0x80000000, NV=1.
  - Unsigned, positive: if ovf or rmag>0xFFFFFFFF → 0xFFFFFFFF, NV=1.
  - Unsigned, negative with rmag!=0 → 0x00000000, NV=1.
  - Unsigned, negative with rmag==0 → 0x00000000, NX=inexact.
  - Otherwise → result = sign ? -rmag : rmag, NX=inexact.
  - NV and NX are never set together.
- Zero and denormal inputs: mag=0; sticky = (m!=0). ±0 gives 0 with no flags.

## Timing
- Latency: 3 cycles from the accepted input to out_valid, with no stalls. Throughput is 1 per cycle.
- While out_valid && !out_ready:
  - All stages hold.
  - in_ready=0.
  - result and fflags remain stable.
- A bubble (in_valid=0 while adv=1) propagates as an invalid stage. Bubbles are not squeezed out.
- Reset values: out_valid=0, result=0, fflags=0, all stage valids 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are dropped. No out_valid is produced for them.

## Configuration
- FPCVT_RM_EN defined: rm is honored as specified.
  - rm values 101, 110 and 111 are treated as RTZ.
- FPCVT_RM_EN undefined: rm is ignored and all conversions use RTZ.
  - The rounding incrementer is removed; inexact detection and NX are kept.

## Test plan
1. rs1=0x40490FDB (3.14159), signed, RNE → result 0x00000003, fflags 0x01. out_valid exactly 3 cycles after acceptance.
2. Rounding, with FPCVT_RM_EN:
   - 0x3FC00000 (1.5): RNE→2, RTZ→1.
   - 0x40200000 (2.5): RNE→2, RMM→3.
   - 0xBFC00000 (-1.5): RDN→0xFFFFFFFE, RUP→0xFFFFFFFF.
   - All of the above set NX.
3. Range limits:
   - 0x4F000000 (2^31) signed → 0x7FFFFFFF, NV; unsigned → 0x80000000, no flags.
   - 0xCF000000 signed → 0x80000000, no flags.
   - 0x4F800000 unsigned → 0xFFFFFFFF, NV.
4. Specials:
   - 0x7FC00000 signed → 0x7FFFFFFF, NV.
   - 0xFF800000 unsigned → 0, NV.
   - 0xBE99999A (-0.3) unsigned RTZ → 0, NX only.
   - 0x00000001 signed → 0, NX.
5. Backpressure: 6 back-to-back inputs (1.0 through 6.0); out_ready held low for 4 cycles after the 2nd output.
   - Outputs are 1..6, in order, with none lost or duplicated.
   - in_ready=0 exactly while stalled.
6. Reset: resetn pulsed low with 3 operations in flight → out_valid=0, result=0, fflags=0 next cycle. No stale outputs appear afterwards.
